mmu_port_arbiter: RTL
=====================

MMU_PORT_ARBITER -- requirements
Module: mmu_port_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, meaning the number of requester ports (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-004 SHALL have parameter MODE, default ARB_RR, meaning the arbitration policy (ARB_FIXED or ARB_RR).
REQ-005 SHALL have parameter LOCK_MAX, default 16, meaning the maximum number of cycles a port may hold a lock.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port req_valid, input, N_PORTS bits: per-port request valid.
REQ-009 SHALL have port req_ready, output, N_PORTS bits: per-port grant.
REQ-010 SHALL have port req_addr, input, N_PORTS*ADDR_W bits: flattened per-port address.
REQ-011 SHALL have port req_wr_ena, input, N_PORTS bits: per-port write enable.
REQ-012 SHALL have port req_wr_data, input, N_PORTS*DATA_W bits: flattened per-port write data.
REQ-013 SHALL have port req_lock, input, N_PORTS bits: keep the grant after this transfer.
REQ-014 SHALL have port rsp_valid, output, N_PORTS bits: read data valid for that port.
REQ-015 SHALL have port rsp_data, output, DATA_W bits: read data, shared by all ports.
REQ-016 SHALL have ports mem_addr (output, ADDR_W), mem_wr_ena (output, 1), mem_wr_data (output, DATA_W) and mem_rd_data (input, DATA_W): the downstream MMU port, with synchronous read data one cycle after the address.
REQ-017 SHALL have port lock_timeout, output, 1 bit: sticky lock-timeout error flag.

Function
REQ-018 SHALL assert at most one req_ready bit per cycle; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-019 SHALL compute req_ready combinationally from req_valid in the same cycle, with zero-cycle grant latency.
REQ-020 SHALL grant the lowest-index valid port when MODE=ARB_FIXED.
REQ-021 SHALL, when MODE=ARB_RR, search from last_grant+1 and wrap modulo N_PORTS; last_grant updates only on a transfer.
REQ-022 SHALL drive mem_addr, mem_wr_data and mem_wr_ena from the winning port; mem_wr_ena is high only for a winning write.
REQ-023 SHALL drive mem_addr=0, mem_wr_ena=0 and mem_wr_data=0 when there is no winner.
REQ-024 SHALL, for an accepted read from port i in cycle t, pulse rsp_valid[i] for exactly one cycle in t+1, with rsp_data=mem_rd_data.
REQ-025 SHALL keep rsp_valid low after writes.
REQ-026 SHALL hold rsp_data when no response is valid.
REQ-027 SHALL implement a lock FSM with states UNLOCKED and LOCKED, with owner and age registers.
REQ-028 SHALL move UNLOCKED->LOCKED on a transfer with req_lock=1, setting owner to that port and age to 0.
REQ-029 SHALL, in LOCKED, grant only the owner, and assert no req_ready while the owner is not valid.
REQ-030 SHALL increment age every LOCKED cycle.
REQ-031 SHALL move LOCKED->UNLOCKED on an owner transfer with req_lock=0; the grant still happens that cycle.
REQ-032 SHALL move LOCKED->UNLOCKED when age reaches LOCK_MAX-1 without release, and set lock_timeout (sticky until reset).
REQ-033 SHALL allow arbitration among all ports in the cycle after a forced release.
REQ-034 SHALL allow a request and a simultaneous response for the same port (back-to-back reads, one per cycle, full throughput).
REQ-035 SHALL treat a port that drops req_valid without a transfer as having no effect on state.

Reset
REQ-036 SHALL, while rst=0, force rsp_valid=0, rsp_data=0, lock_timeout=0, state=UNLOCKED, owner=0, age=0 and last_grant=N_PORTS-1, so port 0 has first priority.
REQ-037 SHALL, on reset mid-lock or mid-read, drop the pending response and the lock, with no rsp_valid pulse after reset release.

Structure
REQ-038 SHALL place the arb_mode_t enum (ARB_FIXED, ARB_RR) and the lock_state_t enum (UNLOCKED, LOCKED) in shared package arb_pkg.
REQ-039 SHALL implement rotating priority selection in sub-module rr_priority_picker, which takes request, start and mask and returns a one-hot grant; fixed mode uses start=0.
REQ-040 SHALL contain about 150-300 lines of RTL with no memories inside.

Verification
REQ-041 SHALL cover: MODE=ARB_RR, N_PORTS=2, both ports reading continuously -> grants alternate 0,1,0,1, and each rsp_valid follows its grant by one cycle with the correct mem_rd_data.
REQ-042 SHALL cover: MODE=ARB_FIXED, ports 0 and 1 always valid -> port 1 is never granted, and port 0 gets 100% of transfers.
REQ-043 SHALL cover: port 1 transfers with lock=1 three times, then lock=0, while port 0 is valid -> port 0 is held off for four transfers and granted in the next cycle.
REQ-044 SHALL cover: LOCK_MAX=4, port 0 locks then drops valid -> forced release after 4 cycles, lock_timeout=1 and stays 1, and port 1 is granted next.
REQ-045 SHALL cover: write from port 1 (addr 0x10, data 0xDEADBEEF) -> mem_wr_ena=1 for one cycle with matching addr and data, and no rsp_valid.
REQ-046 SHALL cover: rst asserted the cycle after an accepted read -> no rsp_valid, all outputs 0, and the first grant after release goes to port 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the MMU port arbiter: arbitration policy and lock FSM states.
package arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating priority picker: first set bit of (req & mask) searching upward from
// start, wrapping around; returns a one-hot grant.
module rr_priority_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic [N-1:0]     mask_i,
  output logic [N-1:0]     grant_o
);

  logic [N-1:0]   eff;
  logic [N-1:0]   rot;
  logic [N-1:0]   first;
  logic [2*N-1:0] dbl_rot;
  logic [2*N-1:0] dbl_grant;

  // Rotate so start lands on bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    eff       = req_i & mask_i;
    dbl_rot   = {eff, eff} >> start_i;
    rot       = dbl_rot[N-1:0];
    first     = rot & (~rot + N'(1));
    dbl_grant = {first, first} << start_i;
    grant_o   = dbl_grant[2*N-1:N];
  end

endmodule

// File: rtl/mmu_port_arbiter.sv
// N-port arbiter in front of a single MMU port: zero-latency grant, optional
// port lock with timeout, and one-cycle read response routing.
module mmu_port_arbiter
  import arb_pkg::*;
#(
  parameter int        N_PORTS  = 2,
  parameter int        ADDR_W   = 32,
  parameter int        DATA_W   = 32,
  parameter arb_mode_t MODE     = ARB_RR,
  parameter int        LOCK_MAX = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         req_valid,
  output logic [N_PORTS-1:0]         req_ready,
  input  logic [N_PORTS*ADDR_W-1:0]  req_addr,
  input  logic [N_PORTS-1:0]         req_wr_ena,
  input  logic [N_PORTS*DATA_W-1:0]  req_wr_data,
  input  logic [N_PORTS-1:0]         req_lock,
  output logic [N_PORTS-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_wr_ena,
  output logic [DATA_W-1:0]          mem_wr_data,
  input  logic [DATA_W-1:0]          mem_rd_data,
  output logic                       lock_timeout
);

  localparam int                 IDX_W    = idx_w(N_PORTS);
  localparam int                 AGE_W    = idx_w(LOCK_MAX);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_PORTS - 1);
  localparam logic [AGE_W-1:0]   AGE_LAST = AGE_W'(LOCK_MAX - 1);
  localparam logic [N_PORTS-1:0] ONE_HOT0 = N_PORTS'(1);

  lock_state_t        state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [AGE_W-1:0]   age_q, age_d;
  logic               timeout_q, timeout_d;
  logic [N_PORTS-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_hold_q;

  logic [IDX_W-1:0]   start;
  logic [IDX_W-1:0]   win_idx;
  logic [N_PORTS-1:0] mask;
  logic [N_PORTS-1:0] grant;
  logic               xfer;
  logic               xfer_lock;

  logic [ADDR_W-1:0]  addr_arr  [N_PORTS];
  logic [DATA_W-1:0]  wdata_arr [N_PORTS];

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wr_data[gi*DATA_W +: DATA_W];
  end

  // Fixed priority is the rotating picker pinned to start at port 0.
  always_comb begin
    if (MODE == ARB_FIXED) begin
      start = '0;
    end else begin
      start = (last_q == LAST_IDX) ? '0 : last_q + IDX_W'(1);
    end
    mask = (state_q == LOCKED) ? (ONE_HOT0 << owner_q) : '1;
  end

  rr_priority_picker #(
    .N     (N_PORTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i   (req_valid),
    .start_i (start),
    .mask_i  (mask),
    .grant_o (grant)
  );

  always_comb begin
    req_ready   = grant;
    mem_addr    = '0;
    mem_wr_ena  = 1'b0;
    mem_wr_data = '0;
    win_idx     = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant[i]) begin
        mem_addr    = addr_arr[i];
        mem_wr_data = wdata_arr[i];
        mem_wr_ena  = req_wr_ena[i];
        win_idx     = IDX_W'(i);
      end
    end
    xfer      = |grant;
    xfer_lock = |(grant & req_lock);
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    age_d       = age_q;
    timeout_d   = timeout_q;
    last_d      = xfer ? win_idx : last_q;
    rsp_valid_d = grant & ~req_wr_ena;
    case (state_q)
      UNLOCKED: begin
        if (xfer_lock) begin
          state_d = LOCKED;
          owner_d = win_idx;
          age_d   = '0;
        end
      end
      LOCKED: begin
        age_d = age_q + AGE_W'(1);
        // An owner release wins over a timeout landing in the same cycle.
        if (xfer && !xfer_lock) begin
          state_d = UNLOCKED;
          age_d   = '0;
        end else if (age_q == AGE_LAST) begin
          state_d   = UNLOCKED;
          age_d     = '0;
          timeout_d = 1'b1;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= UNLOCKED;
      owner_q     <= '0;
      age_q       <= '0;
      last_q      <= LAST_IDX;
      timeout_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      age_q       <= age_d;
      last_q      <= last_d;
      timeout_q   <= timeout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hold_q  <= rsp_data;
    end
  end

  // Read data passes straight through in the response cycle, otherwise held.
  assign rsp_data     = (|rsp_valid_q) ? mem_rd_data : rsp_hold_q;
  assign rsp_valid    = rsp_valid_q;
  assign lock_timeout = timeout_q;

endmodule
